// File: rtl/ktop_axi_mem_responder.sv
// AXI4 slave memory responder: serves INCR read and write bursts from an internal word array.
// Read and write sides are independent FSMs sharing one array, each moving one beat per cycle.
module ktop_axi_mem_responder #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
  parameter int unsigned C_MEM_DEPTH        = 1024
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            err_wlast
);

  localparam int unsigned LP_DW_BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned OffW        = $clog2(LP_DW_BYTES);
  localparam int unsigned IdxW        = $clog2(C_MEM_DEPTH);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic       {RIdle, RData}        r_state_e;

  logic [C_M_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

  w_state_e                      w_state_q, w_state_d;
  logic [IdxW-1:0]               widx_q, widx_d;
  logic [7:0]                    wrem_q, wrem_d;
  logic                          awready_q, awready_d;
  logic                          wready_q, wready_d;
  logic                          bvalid_q, bvalid_d;
  logic                          err_q, err_d;
  logic                          mem_we;

  r_state_e                      r_state_q, r_state_d;
  logic [IdxW-1:0]               ridx_q, ridx_d;
  logic [7:0]                    rrem_q, rrem_d;
  logic                          arready_q, arready_d;
  logic                          rvalid_q, rvalid_d;
  logic                          rlast_q, rlast_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [IdxW-1:0] aw_idx, ar_idx;
  logic            unused_addr_bits;

  // Byte offset and bits above the array range are ignored.
  assign aw_idx           = s_axi_awaddr[OffW+IdxW-1:OffW];
  assign ar_idx           = s_axi_araddr[OffW+IdxW-1:OffW];
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  // Write FSM next-state: AW latch, counted data beats, B response.
  always_comb begin
    w_state_d = w_state_q;
    widx_d    = widx_q;
    wrem_d    = wrem_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && awready_q) begin
          widx_d    = aw_idx;
          wrem_d    = s_axi_awlen;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = WData;
        end
      end
      WData: begin
        if (s_axi_wvalid && wready_q) begin
          mem_we = 1'b1;
          widx_d = widx_q + IdxW'(1);
          wrem_d = wrem_q - 8'd1;
          // Burst end comes from the beat count; wlast is only cross-checked.
          if (s_axi_wlast != (wrem_q == 8'd0)) err_d = 1'b1;
          if (wrem_q == 8'd0) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            w_state_d = WResp;
          end
        end
      end
      WResp: begin
        if (s_axi_bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Write FSM state and registered outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= WIdle;
      widx_q    <= '0;
      wrem_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      widx_q    <= widx_d;
      wrem_q    <= wrem_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      err_q     <= err_d;
    end
  end

  // Array write with byte enables; contents survive reset.
  always_ff @(posedge aclk) begin
    if (mem_we && !areset) begin
      for (int i = 0; i < LP_DW_BYTES; i++) begin
        if (s_axi_wstrb[i]) mem[widx_q][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

  // Read FSM next-state: load the next word on the same edge as each R handshake.
  always_comb begin
    r_state_d = r_state_q;
    ridx_d    = ridx_q;
    rrem_d    = rrem_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      RIdle: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          rdata_d   = mem[ar_idx];
          ridx_d    = ar_idx + IdxW'(1);
          rrem_d    = s_axi_arlen;
          rlast_d   = (s_axi_arlen == 8'd0);
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = RData;
        end
      end
      RData: begin
        if (s_axi_rready && rvalid_q) begin
          if (rrem_q == 8'd0) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            r_state_d = RIdle;
          end else begin
            // ridx_q already points at the word after the one on the bus.
            rdata_d = mem[ridx_q];
            ridx_d  = ridx_q + IdxW'(1);
            rrem_d  = rrem_q - 8'd1;
            rlast_d = (rrem_q == 8'd1);
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  // Read FSM state and registered outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state_q <= RIdle;
      ridx_q    <= '0;
      rrem_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      ridx_q    <= ridx_d;
      rrem_q    <= rrem_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rdata   = rdata_q;
  assign err_wlast     = err_q;

endmodule

// File: tb/tb_ktop_axi_mem_responder.sv
// Directed bench for the AXI memory responder: bursts, stalls, strobes, wrap, wlast error, reset.
module tb_ktop_axi_mem_responder;

  localparam int AW = 64;
  localparam int DW = 512;

  logic          aclk = 1'b0;
  logic          areset;
  logic          s_axi_awvalid, s_axi_awready;
  logic [AW-1:0] s_axi_awaddr;
  logic [7:0]    s_axi_awlen;
  logic          s_axi_wvalid, s_axi_wready;
  logic [DW-1:0] s_axi_wdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic          s_axi_wlast;
  logic          s_axi_bvalid, s_axi_bready;
  logic          s_axi_arvalid, s_axi_arready;
  logic [AW-1:0] s_axi_araddr;
  logic [7:0]    s_axi_arlen;
  logic          s_axi_rvalid, s_axi_rready;
  logic [DW-1:0] s_axi_rdata;
  logic          s_axi_rlast;
  logic          err_wlast;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] wd [8];
  logic [DW-1:0] rd [8];
  logic          rl [8];
  int            rcyc;

  ktop_axi_mem_responder #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_MEM_DEPTH       (1024)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awlen  (s_axi_awlen),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wlast  (s_axi_wlast),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arlen  (s_axi_arlen),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rlast  (s_axi_rlast),
    .err_wlast    (err_wlast)
  );

  always #5 aclk = ~aclk;

  // Drive and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bad_beat: index of a non-final beat that also asserts wlast (-1 for none).
  task automatic write_burst(input logic [AW-1:0] addr, input int len,
                             input logic [DW/8-1:0] strb, input int bad_beat);
    int t;
    s_axi_awaddr  = addr;
    s_axi_awlen   = len[7:0];
    s_axi_awvalid = 1'b1;
    t = 0;
    while (!s_axi_awready && t < 50) begin tick(); t++; end
    check("aw_ready_timeout", s_axi_awready, 1);
    tick();
    s_axi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = wd[b];
      s_axi_wstrb  = strb;
      s_axi_wlast  = (b == len) ^ (b == bad_beat);
      t = 0;
      while (!s_axi_wready && t < 50) begin tick(); t++; end
      check("w_ready_timeout", s_axi_wready, 1);
      tick();
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    check("bvalid_after_last", s_axi_bvalid, 1);
    tick();
    check("bvalid_cleared", s_axi_bvalid, 0);
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input int len, input bit toggle);
    int t;
    int beat;
    int cyc;
    logic [DW-1:0] prev;
    logic prevl;
    bit stalled;
    s_axi_araddr  = addr;
    s_axi_arlen   = len[7:0];
    s_axi_arvalid = 1'b1;
    t = 0;
    while (!s_axi_arready && t < 50) begin tick(); t++; end
    check("ar_ready_timeout", s_axi_arready, 1);
    tick();
    s_axi_arvalid = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat <= len && cyc < 100) begin
      s_axi_rready = !toggle || (cyc % 2 == 0);
      stalled = s_axi_rvalid && !s_axi_rready;
      prev  = s_axi_rdata;
      prevl = s_axi_rlast;
      if (s_axi_rvalid && s_axi_rready) begin
        rd[beat] = s_axi_rdata;
        rl[beat] = s_axi_rlast;
        beat++;
      end
      tick();
      cyc++;
      if (stalled) begin
        check("hold_rvalid", s_axi_rvalid, 1);
        check("hold_rdata", s_axi_rdata, prev);
        check("hold_rlast", s_axi_rlast, prevl);
      end
    end
    s_axi_rready = 1'b0;
    check("r_beats_timeout", beat, len + 1);
    check("rvalid_after_burst", s_axi_rvalid, 0);
    rcyc = cyc;
  endtask

  initial begin
    logic [DW-1:0] exp_strb;
    int t;
    areset = 1'b1;
    s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awlen = '0;
    s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0;
    s_axi_bready = 1'b1;
    s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_rready = 0;
    tick(); tick(); tick();

    // Reset state
    check("rst_awready", s_axi_awready, 0);
    check("rst_wready", s_axi_wready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_arready", s_axi_arready, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_rlast", s_axi_rlast, 0);
    check("rst_err", err_wlast, 0);
    areset = 1'b0;
    tick();

    // Four-beat write 1..4 at word 0, full strobe
    for (int i = 0; i < 4; i++) wd[i] = DW'(i + 1);
    write_burst(64'h0, 3, '1, -1);
    check("w1_err", err_wlast, 0);

    // Four-beat read, rready held high
    read_burst(64'h0, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("r1_data", rd[i], DW'(i + 1));
      check("r1_last", rl[i], (i == 3));
    end
    check("r1_cycles", rcyc, 4);

    // Same burst with rready toggling
    read_burst(64'h0, 3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("r2_data", rd[i], DW'(i + 1));
      check("r2_last", rl[i], (i == 3));
    end

    // Byte strobes on word 1 (addr 0x40): all 0x11, then FF on low 4 bytes
    wd[0] = {64{8'h11}};
    write_burst(64'h40, 0, '1, -1);
    wd[0] = '1;
    write_burst(64'h40, 0, 64'h0F, -1);
    exp_strb = {{60{8'h11}}, 32'hFFFF_FFFF};
    read_burst(64'h40, 0, 1'b0);
    check("strb_data", rd[0], exp_strb);
    check("strb_last", rl[0], 1);

    // Index wrap: word 1023 then word 0
    wd[0] = DW'(32'hA5A5);
    wd[1] = DW'(32'h5A5A);
    write_burst(64'hFFC0, 1, '1, -1);
    read_burst(64'hFFC0, 1, 1'b0);
    check("wrap_rd0", rd[0], DW'(32'hA5A5));
    check("wrap_rd1", rd[1], DW'(32'h5A5A));
    check("wrap_last", rl[1], 1);
    read_burst(64'h0, 0, 1'b0);
    check("wrap_word0", rd[0], DW'(32'h5A5A));
    check("wrap_word1_intact", err_wlast, 0);
    read_burst(64'h40, 0, 1'b0);
    check("word1_intact", rd[0], exp_strb);

    // Early wlast on beat 1 of a 4-beat burst sets sticky error
    for (int i = 0; i < 4; i++) wd[i] = DW'(i + 32'h100);
    write_burst(64'h200, 3, '1, 1);
    check("err_set", err_wlast, 1);
    tick(); tick();
    check("err_sticky", err_wlast, 1);
    wd[0] = DW'(32'h77);
    write_burst(64'h240, 0, '1, -1);
    check("err_sticky_after_good", err_wlast, 1);
    read_burst(64'h200, 3, 1'b0);
    check("err_burst_beat3", rd[3], DW'(32'h103));

    // Reset in the middle of a read burst
    s_axi_araddr  = 64'h0;
    s_axi_arlen   = 8'd7;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b1;
    t = 0;
    while (!s_axi_arready && t < 50) begin tick(); t++; end
    check("rst_ar_timeout", s_axi_arready, 1);
    tick();
    s_axi_arvalid = 1'b0;
    check("mid_rvalid_pre", s_axi_rvalid, 1);
    tick();
    areset = 1'b1;
    tick();
    check("mid_rvalid_post", s_axi_rvalid, 0);
    check("mid_rdata_post", s_axi_rdata, '0);
    check("mid_err_cleared", err_wlast, 0);
    areset = 1'b0;
    s_axi_rready = 1'b0;
    tick();

    // Array contents survive reset
    read_burst(64'h40, 0, 1'b0);
    check("post_rst_word1", rd[0], exp_strb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
